// File: rtl/jtframe_arb_pkg.sv
// Shared types and helpers for the jtframe ROM arbiter.
// The JTFRAME_ARB_RR_EN macro (see jtframe_rom_arb) selects round-robin grants.
package jtframe_arb_pkg;

   localparam int AW_DEF    = 22;
   localparam int DW_DEF    = 32;
   localparam int MAX_SLOTS = 8;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} arb_state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // First set bit of req[n-1:0], searching upward from start and wrapping.
   function automatic pick_t first_set(input logic [MAX_SLOTS-1:0] req,
                                       input logic [2:0]           start,
                                       input logic [3:0]           n);
      pick_t pick;
      int    j;
      pick = '0;
      for (int k = 0; k < MAX_SLOTS; k++) begin
         j = int'(start) + k;
         if (j >= int'(n)) j = j - int'(n);
         if (k < int'(n)) begin
            if (!pick.found && req[3'(j)]) begin
               pick.found = 1'b1;
               pick.idx   = 3'(j);
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/jtframe_arb_slot.sv
// One requester's single-word cache: tag, valid, data, hit compare and the
// registered slot_ok flag.
module jtframe_arb_slot
   import jtframe_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk_rom,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          cs_i,
   input  logic [AW-1:0] addr_i,
   input  logic          inval_i,
   input  logic          fill_i,
   input  logic [AW-1:0] fill_addr_i,
   input  logic [DW-1:0] fill_data_i,
   output logic          hit_o,
   output logic          ok_o,
   output logic [DW-1:0] dout_o
);

   logic [AW-1:0] tag_q;
   logic [DW-1:0] data_q;
   logic          valid_q, valid_d;
   logic          ok_q, ok_d;

   assign hit_o  = valid_q && (tag_q == addr_i);
   assign ok_o   = ok_q;
   assign dout_o = data_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      if (inval_i) valid_d = 1'b0;
      if (fill_i)  valid_d = 1'b1;
      if (clr_i)   valid_d = 1'b0;
      ok_d = cs_i && hit_o && !clr_i;
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         ok_q    <= ok_d;
         if (fill_i) begin
            tag_q  <= fill_addr_i;
            data_q <= fill_data_i;
         end
      end
   end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Arbitrates SLOTS cached ROM requesters onto one SDRAM read port.
// Define JTFRAME_ARB_RR_EN for round-robin grants; default is fixed priority (slot 0 first).
module jtframe_rom_arb
   import jtframe_arb_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic                clk_rom,
   input  logic                rst_n,
   input  logic                downloading,
   input  logic                loop_rst,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS*DW-1:0] slot_dout,
   output logic [SLOTS-1:0]    slot_ok,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic [DW-1:0]       data_read,
   input  logic                data_rdy
);

   arb_state_t           state_q, state_d;
   logic [2:0]           grant_q, grant_d;
   logic                 req_q, req_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic                 issue, fill, clr;
   logic [SLOTS-1:0]     hit;
   logic [MAX_SLOTS-1:0] pend;
   pick_t                pick;
`ifdef JTFRAME_ARB_RR_EN
   logic [2:0]           rr_q, rr_d;
`endif

   assign clr        = downloading || loop_rst;
   assign sdram_req  = req_q;
   assign sdram_addr = addr_q;

   always_comb begin
      pend = '0;
      pend[SLOTS-1:0] = slot_cs & ~hit;
`ifdef JTFRAME_ARB_RR_EN
      pick = first_set(pend, rr_q, 4'(SLOTS));
      rr_d = rr_q;
`else
      pick = first_set(pend, 3'd0, 4'(SLOTS));
`endif
      state_d = state_q;
      grant_d = grant_q;
      req_d   = req_q;
      addr_d  = addr_q;
      issue   = 1'b0;
      fill    = 1'b0;
      unique case (state_q)
         IDLE: if (pick.found) begin
            state_d = WAIT_ACK;
            grant_d = pick.idx;
            req_d   = 1'b1;
            addr_d  = slot_addr[int'(pick.idx)*AW +: AW];
            issue   = 1'b1;
`ifdef JTFRAME_ARB_RR_EN
            rr_d    = (int'(pick.idx) == SLOTS-1) ? 3'd0 : pick.idx + 3'd1;
`endif
         end
         WAIT_ACK: if (sdram_ack) begin
            req_d = 1'b0;
            // A zero-latency controller may return data with the ack.
            if (data_rdy) begin
               fill    = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT_RDY;
            end
         end
         WAIT_RDY: if (data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d = IDLE;
         req_d   = 1'b0;
         grant_d = grant_q;
         addr_d  = addr_q;
         issue   = 1'b0;
         fill    = 1'b0;
`ifdef JTFRAME_ARB_RR_EN
         rr_d    = rr_q;
`endif
      end
   end

   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
`ifdef JTFRAME_ARB_RR_EN
         rr_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
`ifdef JTFRAME_ARB_RR_EN
         rr_q    <= rr_d;
`endif
      end
   end

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      jtframe_arb_slot #(.AW(AW), .DW(DW)) u_slot (
         .clk_rom     (clk_rom),
         .rst_n       (rst_n),
         .clr_i       (clr),
         .cs_i        (slot_cs[i]),
         .addr_i      (slot_addr[i*AW +: AW]),
         .inval_i     (issue && (grant_d == 3'(i))),
         .fill_i      (fill && (grant_q == 3'(i))),
         .fill_addr_i (addr_q),
         .fill_data_i (data_read),
         .hit_o       (hit[i]),
         .ok_o        (slot_ok[i]),
         .dout_o      (slot_dout[i*DW +: DW])
      );
   end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Self-checking bench for jtframe_rom_arb with a behavioural SDRAM responder.
// Grant-order expectations follow JTFRAME_ARB_RR_EN when it is defined.
module tb_jtframe_rom_arb;

   localparam int SLOTS = 4;
   localparam int AW    = 22;
   localparam int DW    = 32;

   logic                clk_rom = 1'b0;
   logic                rst_n;
   logic                downloading, loop_rst;
   logic [SLOTS-1:0]    slot_cs;
   logic [SLOTS*AW-1:0] slot_addr;
   logic [SLOTS*DW-1:0] slot_dout;
   logic [SLOTS-1:0]    slot_ok;
   logic                sdram_req;
   logic [AW-1:0]       sdram_addr;
   logic                sdram_ack;
   logic [DW-1:0]       data_read;
   logic                data_rdy;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_dly  = 2;
   int rdy_dly  = 1;

   logic [AW-1:0] got_q[$];   // addresses acked by the SDRAM model
   logic [AW-1:0] exp_q[$];   // addresses the tests expect to be issued
   int            exp_slot_q[$];

   jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
      .clk_rom     (clk_rom),
      .rst_n       (rst_n),
      .downloading (downloading),
      .loop_rst    (loop_rst),
      .slot_cs     (slot_cs),
      .slot_addr   (slot_addr),
      .slot_dout   (slot_dout),
      .slot_ok     (slot_ok),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_read   (data_read),
      .data_rdy    (data_rdy)
   );

   always #5 clk_rom = ~clk_rom;

   function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
      if (a == 22'h100) return 32'hDEADBEEF;
      return 32'h5A5A0000 ^ {10'd0, a};
   endfunction

   function automatic logic [DW-1:0] dout(input int i);
      return slot_dout[i*DW +: DW];
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      slot_addr[i*AW +: AW] = a;
   endtask

   // SDRAM controller model: ack ack_dly cycles after req, data rdy_dly cycles after ack.
   initial begin
      int            m_st;
      int            m_cnt;
      logic [AW-1:0] m_addr;
      sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
      m_st = 0; m_cnt = 0; m_addr = '0;
      forever begin
         @(negedge clk_rom);
         sdram_ack = 1'b0;
         data_rdy  = 1'b0;
         case (m_st)
            0: if (sdram_req) begin m_st = 1; m_cnt = 1; end
            1: begin
               if (!sdram_req) m_st = 0;
               else if (m_cnt >= ack_dly) begin
                  sdram_ack = 1'b1;
                  m_addr    = sdram_addr;
                  got_q.push_back(sdram_addr);
                  if (rdy_dly == 0) begin
                     data_rdy  = 1'b1;
                     data_read = mem_data(sdram_addr);
                     m_st      = 0;
                  end else begin
                     m_st = 2; m_cnt = 1;
                  end
               end else m_cnt++;
            end
            default: begin
               if (m_cnt >= rdy_dly) begin
                  data_rdy  = 1'b1;
                  data_read = mem_data(m_addr);
                  m_st      = 0;
               end else m_cnt++;
            end
         endcase
      end
   end

   task automatic pop_issue(output logic [AW-1:0] a, output bit got);
      got = 1'b0; a = '0;
      for (int c = 0; c < 60; c++) begin
         if (got_q.size() > 0) begin
            a = got_q.pop_front(); got = 1'b1; break;
         end
         @(negedge clk_rom);
      end
   endtask

   task automatic wait_ok(input int i, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (slot_ok[i]) begin seen = 1'b1; break; end
         @(negedge clk_rom);
      end
   endtask

   task automatic settle();
      slot_cs = '0;
      repeat (10) @(negedge clk_rom);
      got_q.delete();
   endtask

   task automatic test_reset();
      n_checks++; if (sdram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", sdram_req); end
      n_checks++; if (sdram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", sdram_addr); end
      n_checks++; if (slot_ok !== '0) begin n_fail++; $display("FAIL reset_ok: got %b expected 0", slot_ok); end
      n_checks++; if (slot_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", slot_dout); end
   endtask

   task automatic test_single_miss();
      logic [AW-1:0] a, e;
      bit            got, seen;
      exp_q.push_back(22'h100);
      set_addr(0, 22'h100); slot_cs[0] = 1'b1;
      @(negedge clk_rom);
      n_checks++; if (sdram_req !== 1'b1) begin n_fail++; $display("FAIL miss_req: got %b expected 1", sdram_req); end
      n_checks++; if (sdram_addr !== 22'h100) begin n_fail++; $display("FAIL miss_addr: got %h expected 00100", sdram_addr); end
      pop_issue(a, got); e = exp_q.pop_front();
      n_checks++; if (!got || a !== e) begin n_fail++; $display("FAIL miss_issue: got %h (seen %0d) expected %h", a, got, e); end
      wait_ok(0, seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL miss_ok: slot_ok[0] stayed 0, expected 1"); end
      n_checks++; if (dout(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_dout: got %h expected deadbeef", dout(0)); end
   endtask

   task automatic test_hit();
      int req_seen = 0;
      for (int r = 0; r < 3; r++) begin
         slot_cs[0] = 1'b0;
         @(negedge clk_rom); req_seen += int'(sdram_req);
         n_checks++; if (slot_ok[0] !== 1'b0) begin n_fail++; $display("FAIL hit_ok_low: got %b expected 0", slot_ok[0]); end
         slot_cs[0] = 1'b1;
         @(negedge clk_rom); req_seen += int'(sdram_req);
         n_checks++; if (slot_ok[0] !== 1'b1) begin n_fail++; $display("FAIL hit_ok_high: got %b expected 1", slot_ok[0]); end
      end
      n_checks++; if (req_seen != 0 || got_q.size() != 0) begin n_fail++; $display("FAIL hit_no_req: got %0d req cycles expected 0", req_seen); end
      settle();
   endtask

   task automatic test_contention();
      logic [AW-1:0] a, e;
      bit            got, seen;
      exp_q.push_back(22'h110); exp_q.push_back(22'h330);
      set_addr(1, 22'h110); set_addr(3, 22'h330);
      slot_cs[1] = 1'b1; slot_cs[3] = 1'b1;
      for (int t = 0; t < 2; t++) begin
         pop_issue(a, got); e = exp_q.pop_front();
         n_checks++; if (!got || a !== e) begin n_fail++; $display("FAIL contention_order%0d: got %h (seen %0d) expected %h", t, a, got, e); end
      end
      wait_ok(3, seen);
      n_checks++; if (!seen || !slot_ok[1]) begin n_fail++; $display("FAIL contention_ok: got %b expected 1x1x", slot_ok); end
      n_checks++; if (dout(1) !== mem_data(22'h110) || dout(3) !== mem_data(22'h330)) begin
         n_fail++; $display("FAIL contention_dout: got %h/%h expected %h/%h", dout(1), dout(3), mem_data(22'h110), mem_data(22'h330));
      end
      settle();
   endtask

   task automatic test_zero_latency();
      logic [AW-1:0] a, e;
      bit            got, seen;
      rdy_dly = 0;
      exp_q.push_back(22'h200);
      set_addr(0, 22'h200); slot_cs[0] = 1'b1;
      pop_issue(a, got); e = exp_q.pop_front();
      n_checks++; if (!got || a !== e) begin n_fail++; $display("FAIL zlat_issue: got %h (seen %0d) expected %h", a, got, e); end
      wait_ok(0, seen);
      n_checks++; if (!seen || dout(0) !== mem_data(22'h200)) begin n_fail++; $display("FAIL zlat_dout: got %h ok %0d expected %h", dout(0), seen, mem_data(22'h200)); end
      rdy_dly = 1;
      settle();
   endtask

   task automatic test_addr_change();
      logic [AW-1:0] a, e;
      bit            got, seen_req, seen_drop, seen_ok;
      int            stale = 0;
      rdy_dly = 3;
      exp_q.push_back(22'h20); exp_q.push_back(22'h24);
      set_addr(2, 22'h20); slot_cs[2] = 1'b1;
      seen_req = 1'b0; seen_drop = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_rom);
         if (sdram_req) seen_req = 1'b1;
         else if (seen_req) begin seen_drop = 1'b1; break; end
      end
      n_checks++; if (!seen_drop) begin n_fail++; $display("FAIL chg_wait_rdy: req seen %0d dropped %0d expected 1/1", seen_req, seen_drop); end
      set_addr(2, 22'h24);
      seen_ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_rom);
         if (slot_ok[2]) begin
            if (dout(2) !== mem_data(22'h24)) stale++;
            seen_ok = 1'b1; break;
         end
      end
      n_checks++; if (stale != 0 || !seen_ok) begin n_fail++; $display("FAIL chg_stale_ok: got stale %0d ok %0d expected 0/1", stale, seen_ok); end
      for (int t = 0; t < 2; t++) begin
         pop_issue(a, got); e = exp_q.pop_front();
         n_checks++; if (!got || a !== e) begin n_fail++; $display("FAIL chg_issue%0d: got %h (seen %0d) expected %h", t, a, got, e); end
      end
      rdy_dly = 1;
      settle();
   endtask

   task automatic test_idle_force();
      bit seen_req = 1'b0;
      ack_dly = 5;
      set_addr(1, 22'h110); set_addr(3, 22'h300);
      slot_cs[1] = 1'b1; slot_cs[3] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_rom);
         if (sdram_req) begin seen_req = 1'b1; break; end
      end
      n_checks++; if (!seen_req || slot_ok[1] !== 1'b1) begin n_fail++; $display("FAIL idle_pre: got req %0d ok1 %b expected 1/1", seen_req, slot_ok[1]); end
      downloading = 1'b1;
      @(negedge clk_rom);
      n_checks++; if (sdram_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b expected 0", sdram_req); end
      n_checks++; if (slot_ok !== '0) begin n_fail++; $display("FAIL idle_ok: got %b expected 0", slot_ok); end
      n_checks++; if (dout(1) !== mem_data(22'h110)) begin n_fail++; $display("FAIL idle_data_kept: got %h expected %h", dout(1), mem_data(22'h110)); end
      slot_cs = '0; downloading = 1'b0;
      repeat (8) @(negedge clk_rom);
      n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL idle_no_ack: got %0d acks expected 0", got_q.size()); end
      ack_dly = 2;
      settle();
   endtask

   task automatic test_async_reset();
      logic [AW-1:0] a, e;
      bit            got, seen;
      exp_q.push_back(22'h500);
      set_addr(0, 22'h500); slot_cs[0] = 1'b1;
      pop_issue(a, got); e = exp_q.pop_front();
      n_checks++; if (!got || a !== e) begin n_fail++; $display("FAIL arst_issue: got %h (seen %0d) expected %h", a, got, e); end
      wait_ok(0, seen);
      @(negedge clk_rom);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (sdram_req !== 1'b0 || sdram_addr !== '0) begin n_fail++; $display("FAIL arst_sdram: got %b/%h expected 0/0", sdram_req, sdram_addr); end
      n_checks++; if (slot_ok !== '0) begin n_fail++; $display("FAIL arst_ok: got %b expected 0", slot_ok); end
      n_checks++; if (slot_dout !== '0) begin n_fail++; $display("FAIL arst_dout: got %h expected 0", slot_dout); end
      slot_cs = '0;
      @(negedge clk_rom);
      rst_n = 1'b1;
      settle();
   endtask

   task automatic test_grant_order();
      logic [AW-1:0] a;
      bit            got;
      int            k, e;
`ifdef JTFRAME_ARB_RR_EN
      for (int t = 0; t < 5; t++) exp_slot_q.push_back(t % SLOTS);
`else
      for (int t = 0; t < 5; t++) exp_slot_q.push_back(0);
`endif
      for (int i = 0; i < SLOTS; i++) set_addr(i, 22'h400 + 22'(i * 16));
      slot_cs = '1;
      for (int t = 0; t < 5; t++) begin
         pop_issue(a, got); e = exp_slot_q.pop_front();
         k = int'(a[5:4]);
         n_checks++; if (!got || k != e) begin n_fail++; $display("FAIL grant_order%0d: got slot %0d (seen %0d) expected %0d", t, k, got, e); end
         if (got) set_addr(k, a + 22'h1000);
      end
      settle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
      slot_cs = '0; slot_addr = '0;
      repeat (2) @(negedge clk_rom);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk_rom);
      test_single_miss();
      test_hit();
      test_contention();
      test_zero_latency();
      test_addr_change();
      test_idle_force();
      test_async_reset();
      test_grant_order();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jtframe_rom_arb.md
Name: jtframe_rom_arb

Overview:
- Shares the single SDRAM read port of the board (sdram_req/ack/addr, data_read/data_rdy) between SLOTS game-side ROM requesters, e.g. main CPU, sound CPU, char, obj.
- Each slot has a one-entry 32-bit cache tagged with the last fetched address, so repeated reads of the same word do not touch SDRAM.
- Sits between the game core and the board SDRAM controller in the clk_rom domain.

Parameters:
- SLOTS, 4: number of requesters (2..8).
- AW, 22: SDRAM word address width.
- DW, 32: data_read width.

Ports:
- clk_rom  in  1  SDRAM/ROM clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- downloading  in  1  ROM load in progress; arbiter held idle.
- loop_rst  in  1  SDRAM controller init; arbiter held idle.
- slot_cs  in  SLOTS  per-slot read request level.
- slot_addr  in  SLOTS*AW  per-slot word address, slot i at [i*AW +: AW].
- slot_dout  out  SLOTS*DW  per-slot cached data.
- slot_ok  out  SLOTS  slot_dout valid for the current slot_addr.
- sdram_req  out  1  request to the board controller.
- sdram_addr  out  AW  address of the granted slot.
- sdram_ack  in  1  controller accepted the request.
- data_read  in  DW  SDRAM read data.
- data_rdy  in  1  data_read valid, one-cycle pulse.

Behaviour:
- Reset (async, rst_n low): state=IDLE, sdram_req=0, sdram_addr=0, all slot_dout=0, all slot_ok=0, all tag valid=0, grant=0, rr pointer=0.
- Per slot i keeps tag_addr[i] (AW bits), valid[i] and data[i]. hit[i] = valid[i] && tag_addr[i]==slot_addr[i].
- slot_ok[i] is registered: slot_ok[i] <= slot_cs[i] && hit[i]. This gives a 1-cycle latency for a cached word. slot_ok drops the cycle after cs falls or the address changes.
- pending[i] = slot_cs[i] && !hit[i].
- FSM states:
  - IDLE: if any pending, choose a grant per the priority rule, then sdram_req<=1, sdram_addr<=slot_addr[grant], valid[grant]<=0, go to WAIT_ACK.
  - WAIT_ACK: hold req and addr. On sdram_ack, sdram_req<=0 and go to WAIT_RDY.
  - WAIT_RDY: on data_rdy, data[grant]<=data_read, tag_addr[grant]<=the issued sdram_addr, valid[grant]<=1, go to IDLE.
- data_rdy in the same cycle as sdram_ack (zero-latency controller): accept both and go directly to IDLE with the data stored.
- Address change mid-fetch: the fetched word is stored under the old tag. The slot then misses and is re-requested from IDLE. No stale slot_ok is ever raised.
- A slot whose cs falls mid-fetch still completes and caches its word. The transaction is never aborted toward SDRAM.
- downloading or loop_rst high: synchronously force IDLE, sdram_req=0, clear all valid and slot_ok. Data registers are kept.
- Only one outstanding SDRAM transaction at any time. A new grant needs at least one IDLE cycle after completion.
- Default priority is fixed: the lowest index wins.
- slot_dout[i] = data[i], a direct register output.

Optional Feature:
- JTFRAME_ARB_RR_EN defined: round-robin grant. The search starts at rr pointer, and rr<=grant+1 (mod SLOTS) on each issue. No slot waits more than SLOTS-1 transactions.
- Undefined: fixed priority as above; the rr register is absent.

Decomposition:
- Package jtframe_arb_pkg holds:
  - the state enum {IDLE, WAIT_ACK, WAIT_RDY};
  - localparam defaults AW=22 and DW=32;
  - a function computing the first set bit from a start index, shared by the fixed and round-robin modes.
- One sub-module: jtframe_arb_slot, which holds the per-slot tag/valid/data registers, hit compare and slot_ok register, instantiated SLOTS times by a generate loop.

Test Plan:
- Single miss: slot0 cs=1, addr=0x00100. Expect:
  - sdram_req=1 with sdram_addr=0x00100 the next cycle;
  - ack after 2 cycles, then data_rdy with 0xDEADBEEF;
  - slot_ok[0]=1 one cycle later, slot_dout[0]=0xDEADBEEF.
- Hit: keep slot0 addr=0x00100 with cs toggling. Expect no further sdram_req and slot_ok[0] high 1 cycle after each cs rise.
- Contention, fixed priority: slots 3 and 1 both miss in the same cycle. Expect slot1 served first, then slot3, with two separate req/ack/rdy sequences.
- Round-robin (JTFRAME_ARB_RR_EN): all 4 slots miss continuously on changing addresses. Expect grants in order 0,1,2,3,0.
- Address change mid-fetch: slot2 addr moves 0x20→0x24 during WAIT_RDY. Expect slot_ok[2] to stay 0 and a second request at 0x24.
- Reset/idle: downloading=1 during WAIT_ACK → sdram_req=0 next cycle and slot_ok all 0. Async rst_n low mid-cycle → all outputs 0 immediately.
